// File: rtl/stage_nhead_seq.sv
// One transformer-like stage: sequences N_HEAD external attention heads over a token,
// adds the first residual, runs MLP_LAYERS scalar MLP layers, then adds the second residual.
module stage_nhead_seq #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned N_HEAD     = 4,
  parameter int unsigned MLP_LAYERS = 2,
  parameter int unsigned FRAC       = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         head_start,
  output logic [((N_HEAD > 1) ? $clog2(N_HEAD) : 1)-1:0] head_sel,
  output logic [DATA_W-1:0]            head_in,
  input  logic                         head_done,
  input  logic [DATA_W-1:0]            head_data,
  input  logic [MLP_LAYERS*DATA_W-1:0] mlp_w,
  input  logic [MLP_LAYERS*DATA_W-1:0] mlp_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         busy,
  output logic                         end_s
);

  localparam int unsigned SEL_W = (N_HEAD > 1) ? $clog2(N_HEAD) : 1;
  localparam int unsigned LAY_W = (MLP_LAYERS > 1) ? $clog2(MLP_LAYERS) : 1;
  // Wide enough for a full signed product plus a bias without wrap.
  localparam int unsigned BIG_W = 2 * DATA_W + 2;

  localparam logic signed [BIG_W-1:0] SAT_MAX = {{(BIG_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [BIG_W-1:0] SAT_MIN = {{(BIG_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD_REQ, S_HEAD_WAIT, S_RES, S_MLP, S_OUT
  } state_t;

  state_t state, state_n;

  logic signed [DATA_W-1:0] x, x_n;
  logic signed [DATA_W-1:0] acc, acc_n;
  logic signed [DATA_W-1:0] r, r_n;
  logic signed [DATA_W-1:0] m, m_n;
  logic signed [DATA_W-1:0] out_q, out_n;
  logic [SEL_W-1:0]         idx, idx_n;
  logic [LAY_W-1:0]         layer, layer_n;
  logic                     end_n;

  logic signed [DATA_W-1:0] w_l, b_l;
  logic signed [DATA_W-1:0] head_sum, res_sum, mlp_new, out_sum;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [BIG_W-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                  sat = v[DATA_W-1:0];
  endfunction

  // Datapath arithmetic, all evaluated at BIG_W before clamping.
  always_comb begin
    w_l      = mlp_w[int'(layer)*DATA_W +: DATA_W];
    b_l      = mlp_b[int'(layer)*DATA_W +: DATA_W];
    head_sum = sat(BIG_W'(acc) + BIG_W'($signed(head_data)));
    res_sum  = sat(BIG_W'(acc) + BIG_W'(x));
    mlp_new  = sat(((BIG_W'(m) * BIG_W'(w_l)) >>> FRAC) + BIG_W'(b_l));
    out_sum  = sat(BIG_W'(mlp_new) + BIG_W'(r));
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n = state;
    x_n     = x;
    acc_n   = acc;
    r_n     = r;
    m_n     = m;
    out_n   = out_q;
    idx_n   = idx;
    layer_n = layer;
    end_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          x_n     = $signed(in_data);
          acc_n   = '0;
          idx_n   = '0;
          state_n = S_HEAD_REQ;
        end
      end
      S_HEAD_REQ: state_n = S_HEAD_WAIT;
      S_HEAD_WAIT: begin
        if (head_done) begin
          acc_n = head_sum;
          if (idx == SEL_W'(N_HEAD - 1)) begin
            state_n = S_RES;
          end else begin
            idx_n   = idx + SEL_W'(1);
            state_n = S_HEAD_REQ;
          end
        end
      end
      S_RES: begin
        r_n     = res_sum;
        m_n     = res_sum;
        layer_n = '0;
        state_n = S_MLP;
      end
      S_MLP: begin
        m_n = mlp_new;
        if (layer == LAY_W'(MLP_LAYERS - 1)) begin
          out_n   = out_sum;
          state_n = S_OUT;
        end else begin
          layer_n = layer + LAY_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          end_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state      <= S_IDLE;
      x          <= '0;
      acc        <= '0;
      r          <= '0;
      m          <= '0;
      out_q      <= '0;
      idx        <= '0;
      layer      <= '0;
      in_ready   <= 1'b1;
      head_start <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      end_s      <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      acc        <= acc_n;
      r          <= r_n;
      m          <= m_n;
      out_q      <= out_n;
      idx        <= idx_n;
      layer      <= layer_n;
      in_ready   <= (state_n == S_IDLE);
      head_start <= (state_n == S_HEAD_REQ);
      out_valid  <= (state_n == S_OUT);
      busy       <= (state_n != S_IDLE);
      end_s      <= end_n;
    end
  end

  assign head_sel = idx;
  assign head_in  = x;
  assign out_data = out_q;

endmodule

// File: tb/tb_stage_nhead_seq.sv
// Directed bench for stage_nhead_seq with N_HEAD=2, MLP_LAYERS=2, FRAC=8.
module tb_stage_nhead_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned NH = 2;
  localparam int unsigned NL = 2;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_data;
  logic                    head_start;
  logic [0:0]              head_sel;
  logic signed [DW-1:0]    head_in;
  logic                    head_done;
  logic signed [DW-1:0]    head_data;
  logic [NL*DW-1:0]        mlp_w;
  logic [NL*DW-1:0]        mlp_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    out_data;
  logic                    busy;
  logic                    end_s;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int x, h0, h1, w0, b0, w1, b1, exp;
  } vec_t;

  vec_t tab[7];

  stage_nhead_seq #(.DATA_W(DW), .N_HEAD(NH), .MLP_LAYERS(NL), .FRAC(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .head_start(head_start), .head_sel(head_sel), .head_in(head_in),
    .head_done(head_done), .head_data(head_data), .mlp_w(mlp_w), .mlp_b(mlp_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .end_s(end_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for head_start with a cycle bound.
  task automatic wait_start();
    int n = 0;
    while (!head_start && n < 50) begin
      step();
      n++;
    end
    chk("head_start_seen", int'(head_start), 1);
  endtask

  task automatic run_vec(input vec_t v, input int dly, input int stall, input bit chk_lat);
    int n;
    chk("idle_in_ready", int'(in_ready), 1);
    mlp_w    = {DW'(v.w1), DW'(v.w0)};
    mlp_b    = {DW'(v.b1), DW'(v.b0)};
    in_data  = DW'(v.x);
    in_valid = 1'b1;
    cyc = 0;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    for (int h = 0; h < int'(NH); h++) begin
      wait_start();
      chk("head_sel", int'(head_sel), h);
      chk("head_in", int'(head_in), v.x);
      step();
      chk("head_start_one_cycle", int'(head_start), 0);
      for (int d = 0; d < dly; d++) begin
        step();
        chk("head_start_quiet", int'(head_start), 0);
        chk("in_ready_busy", int'(in_ready), 0);
      end
      head_done = 1'b1;
      head_data = DW'((h == 0) ? v.h0 : v.h1);
      step();
      head_done = 1'b0;
    end
    // A stray head_done during RES/MLP/OUT must not disturb the result.
    if (stall > 0) begin
      head_done = 1'b1;
      head_data = DW'(1000);
    end
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    if (chk_lat) chk("latency", cyc, 2 * int'(NH) + int'(NL) + 2);
    for (int s = 0; s < stall; s++) begin
      chk("stall_data", int'(out_data), v.exp);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_end_s", int'(end_s), 0);
      step();
    end
    head_done = 1'b0;
    chk("out_data", int'(out_data), v.exp);
    chk("out_valid_hold", int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("end_s_pulse", int'(end_s), 1);
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_back", int'(in_ready), 1);
    step();
    chk("end_s_once", int'(end_s), 0);
  endtask

  initial begin
    tab[0] = '{100, 10, 20, 256, 0, 256, 0, 260};
    tab[1] = '{100, 0, 0, 128, 3, 256, 0, 153};
    tab[2] = '{30000, 5000, 0, 256, 0, 256, 0, 32767};
    tab[3] = '{-30000, -5000, 0, 256, 0, 256, 0, -32768};
    tab[4] = '{-3, 0, 0, 128, 0, 256, 0, -5};
    tab[5] = '{1000, -200, 50, 512, -7, -256, 100, -743};
    tab[6] = '{5, 0, 0, -128, 0, 256, 1, 3};

    rstn = 1'b1; in_valid = 1'b0; in_data = '0; head_done = 1'b0; head_data = '0;
    mlp_w = '0; mlp_b = '0; out_ready = 1'b0; cyc = 0;
    step(); step();
    rstn = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_head_start", int'(head_start), 0);
    chk("rst_head_sel", int'(head_sel), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_end_s", int'(end_s), 0);
    step();

    foreach (tab[i]) run_vec(tab[i], 0, 0, 1'b1);

    run_vec(tab[1], 3, 5, 1'b0);

    // Reset while waiting on a head, then a late head_done.
    mlp_w = {DW'(256), DW'(256)};
    mlp_b = '0;
    in_data = DW'(77);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_start();
    step();
    chk("mid_busy", int'(busy), 1);
    rstn = 1'b1;
    step();
    rstn = 1'b0;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_head_sel", int'(head_sel), 0);
    head_done = 1'b1;
    head_data = DW'(500);
    step();
    head_done = 1'b0;
    chk("late_done_busy", int'(busy), 0);
    chk("late_done_in_ready", int'(in_ready), 1);
    chk("late_done_head_start", int'(head_start), 0);
    run_vec(tab[5], 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
